// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit for a single-port data BRAM
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses
// instead of silently aligning them.
module load_store_unit #(
   parameter int ADDR_WIDTH   = 14,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic                  req_we_in,
   input  logic [2:0]            req_funct3_in,
   input  logic [31:0]           req_addr_in,
   input  logic [31:0]           req_wdata_in,
   output logic                  resp_valid_out,
   output logic [31:0]           resp_data_out,
   output logic                  resp_err_out,
   output logic                  mem_en_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [3:0]            mem_we_out,
   output logic [31:0]           mem_wdata_out,
   input  logic [31:0]           mem_rdata_in
);

   localparam int               CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  we_q;
   logic                  err_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic                  resp_valid_q;
   logic                  resp_err_q;
   logic [31:0]           resp_data_q;
   logic                  mem_en_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [3:0]            mem_we_q;
   logic [31:0]           mem_wdata_q;

   logic                  req_legal;
   logic                  req_err;
   logic [1:0]            req_off;
   logic [3:0]            req_be;
   logic [31:0]           req_wdata_rep;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                  req_misal;
`endif

   // Address bits above the BRAM range are deliberately dropped (wrap-around).
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr_in[31:ADDR_WIDTH+2];

   // Decode the incoming request: legality, effective lane offset, byte enables.
   always_comb begin
      req_off   = req_addr_in[1:0];
      req_legal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      req_misal = 1'b0;
`endif
      case (req_funct3_in)
         3'b000: req_legal = 1'b1;
         3'b001: begin
            req_legal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            req_misal = req_addr_in[0];
`else
            req_off[0] = 1'b0;
`endif
         end
         3'b010: begin
            req_legal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            req_misal = |req_addr_in[1:0];
`else
            req_off = 2'b00;
`endif
         end
         3'b100, 3'b101: req_legal = !req_we_in;
         default:        req_legal = 1'b0;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      req_err = !req_legal || req_misal;
`else
      req_err = !req_legal;
`endif
      case (req_funct3_in[1:0])
         2'b00: begin
            req_be        = 4'b0001 << req_off;
            req_wdata_rep = {4{req_wdata_in[7:0]}};
         end
         2'b01: begin
            req_be        = req_off[1] ? 4'b1100 : 4'b0011;
            req_wdata_rep = {2{req_wdata_in[15:0]}};
         end
         default: begin
            req_be        = 4'b1111;
            req_wdata_rep = req_wdata_in;
         end
      endcase
   end

   // Pick the addressed lane from the read word and extend it to 32 bits.
   always_comb begin
      case (off_q)
         2'd0:    ld_byte = mem_rdata_in[7:0];
         2'd1:    ld_byte = mem_rdata_in[15:8];
         2'd2:    ld_byte = mem_rdata_in[23:16];
         default: ld_byte = mem_rdata_in[31:24];
      endcase
      ld_half = off_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata_in;
      endcase
   end

   // Request sequencer: all memory and response outputs are registered here.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'd0;
         mem_en_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 4'b0000;
         mem_wdata_q  <= 32'd0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'd0;
         mem_en_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 4'b0000;
         mem_wdata_q  <= 32'd0;
         case (state_q)
            S_IDLE: begin
               if (req_valid_in) begin
                  we_q     <= req_we_in;
                  err_q    <= req_err;
                  funct3_q <= req_funct3_in;
                  off_q    <= req_off;
                  if (!req_err) begin
                     mem_en_q   <= 1'b1;
                     mem_addr_q <= req_addr_in[ADDR_WIDTH+1:2];
                     if (req_we_in) begin
                        mem_we_q    <= req_be;
                        mem_wdata_q <= req_wdata_rep;
                     end
                  end
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (err_q || we_q) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= ld_data;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_out  = rst_n_in && (state_q == S_IDLE);
   assign resp_valid_out = resp_valid_q;
   assign resp_err_out   = resp_err_q;
   assign resp_data_out  = resp_data_q;
   assign mem_en_out     = mem_en_q;
   assign mem_addr_out   = mem_addr_q;
   assign mem_we_out     = mem_we_q;
   assign mem_wdata_out  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a BRAM model
module tb_load_store_unit;

   localparam int AW = 14;
   localparam int RL = 2;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          req_valid_in = 1'b0;
   logic          req_ready_out;
   logic          req_we_in = 1'b0;
   logic [2:0]    req_funct3_in = 3'b000;
   logic [31:0]   req_addr_in = 32'd0;
   logic [31:0]   req_wdata_in = 32'd0;
   logic          resp_valid_out;
   logic [31:0]   resp_data_out;
   logic          resp_err_out;
   logic          mem_en_out;
   logic [AW-1:0] mem_addr_out;
   logic [3:0]    mem_we_out;
   logic [31:0]   mem_wdata_out;
   logic [31:0]   mem_rdata_in;

   load_store_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_we_in(req_we_in), .req_funct3_in(req_funct3_in),
      .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
      .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
      .resp_err_out(resp_err_out), .mem_en_out(mem_en_out),
      .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
      .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   // BRAM model: byte-enabled write, two-stage registered read
   logic [31:0] mem [0:(1<<AW)-1];
   logic [31:0] rd_p0 = 32'd0;
   logic [31:0] rd_p1 = 32'd0;
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = 32'd0;
   always @(posedge clk_in) begin
      if (mem_en_out) begin
         for (int b = 0; b < 4; b++)
            if (mem_we_out[b]) mem[mem_addr_out][8*b +: 8] <= mem_wdata_out[8*b +: 8];
         rd_p0 <= mem[mem_addr_out];
      end
      rd_p1 <= rd_p0;
   end
   assign mem_rdata_in = rd_p1;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response pulse is matched against the oldest expectation
   always @(negedge clk_in) begin
      if (resp_valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_err", {31'd0, resp_err_out}, {31'd0, e.err});
            chk("resp_data", resp_data_out, e.data);
            chk("resp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk_in);
      while (!req_ready_out && n < 20) begin
         @(negedge clk_in);
         n++;
      end
      if (!req_ready_out) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk_in);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: got %0d pending responses expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_en, input logic [AW-1:0] exp_addr,
                        input logic [3:0] exp_we, input logic [31:0] exp_wd,
                        input logic exp_err, input logic [31:0] exp_data);
      exp_t e;
      wait_ready();
      e.err  = exp_err;
      e.data = exp_data;
      e.acc  = cyc;
      e.lat  = (exp_err || we) ? 2 : RL + 2;
      sb.push_back(e);
      req_valid_in  = 1'b1;
      req_we_in     = we;
      req_funct3_in = f3;
      req_addr_in   = addr;
      req_wdata_in  = wd;
      @(negedge clk_in);
      req_valid_in  = 1'b0;
      req_we_in     = 1'b0;
      req_funct3_in = 3'b000;
      req_addr_in   = 32'd0;
      req_wdata_in  = 32'd0;
      chk({name, "_mem_en"}, {31'd0, mem_en_out}, {31'd0, exp_en});
      chk({name, "_mem_addr"}, {{(32-AW){1'b0}}, mem_addr_out}, {{(32-AW){1'b0}}, exp_addr});
      chk({name, "_mem_we"}, {28'd0, mem_we_out}, {28'd0, exp_we});
      chk({name, "_mem_wdata"}, mem_wdata_out, exp_wd);
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int n0;
      // reset state
      repeat (3) @(negedge clk_in);
      chk("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en_out}, 32'd0);
      chk("rst_resp_data", resp_data_out, 32'd0);
      rst_n_in = 1'b1;
      #1;
      chk("rst_ready", {31'd0, req_ready_out}, 32'd1);

      // word, byte and half accesses
      issue("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 14'd4, 4'b1111, 32'hDEADBEEF, 1'b0, 32'd0);
      issue("lw10", 1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'hDEADBEEF);
      issue("sb13", 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b1, 14'd4, 4'b1000, 32'h80808080, 1'b0, 32'd0);
      issue("lb13", 1'b0, 3'b000, 32'h13, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'hFFFFFF80);
      issue("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'h00000080);
      issue("sh22", 1'b1, 3'b001, 32'h22, 32'h00008001, 1'b1, 14'd8, 4'b1100, 32'h80018001, 1'b0, 32'd0);
      issue("lh22", 1'b0, 3'b001, 32'h22, 32'd0, 1'b1, 14'd8, 4'b0000, 32'd0, 1'b0, 32'hFFFF8001);
      issue("lhu22", 1'b0, 3'b101, 32'h22, 32'd0, 1'b1, 14'd8, 4'b0000, 32'd0, 1'b0, 32'h00008001);
      // word 4 now holds 0x80ADBEEF
      issue("lb12", 1'b0, 3'b000, 32'h12, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'hFFFFFFAD);
      issue("lh10", 1'b0, 3'b001, 32'h10, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'hFFFFBEEF);
      issue("lhu12", 1'b0, 3'b101, 32'h12, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'h000080AD);
`ifdef LSU_MISALIGN_TRAP_EN
      issue("lw11", 1'b0, 3'b010, 32'h11, 32'd0, 1'b0, 14'd0, 4'b0000, 32'd0, 1'b1, 32'd0);
`else
      issue("lw11", 1'b0, 3'b010, 32'h11, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'h80ADBEEF);
`endif
      // illegal encodings
      issue("ld011", 1'b0, 3'b011, 32'h10, 32'd0, 1'b0, 14'd0, 4'b0000, 32'd0, 1'b1, 32'd0);
      issue("st100", 1'b1, 3'b100, 32'h10, 32'h11, 1'b0, 14'd0, 4'b0000, 32'd0, 1'b1, 32'd0);
      issue("ld111", 1'b0, 3'b111, 32'h10, 32'd0, 1'b0, 14'd0, 4'b0000, 32'd0, 1'b1, 32'd0);
      // upper address bits wrap onto the BRAM
      issue("swwrap", 1'b1, 3'b010, 32'h00010010, 32'h12345678, 1'b1, 14'd4, 4'b1111, 32'h12345678, 1'b0, 32'd0);
      issue("lwwrap", 1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'h12345678);

      // valid held high while busy: second request waits for IDLE
      wait_ready();
      n0 = cyc;
      e.err = 1'b1; e.data = 32'd0; e.acc = n0; e.lat = 2;
      sb.push_back(e);
      req_valid_in = 1'b1; req_we_in = 1'b0; req_funct3_in = 3'b011; req_addr_in = 32'h10;
      @(negedge clk_in);
      chk("held_err_mem_en", {31'd0, mem_en_out}, 32'd0);
      chk("held_busy_ready1", {31'd0, req_ready_out}, 32'd0);
      req_funct3_in = 3'b010;
      e.err = 1'b0; e.data = 32'h12345678; e.acc = n0 + 3; e.lat = RL + 2;
      sb.push_back(e);
      @(negedge clk_in);
      chk("held_busy_ready2", {31'd0, req_ready_out}, 32'd0);
      chk("held_no_issue", {31'd0, mem_en_out}, 32'd0);
      @(negedge clk_in);
      chk("held_idle_ready", {31'd0, req_ready_out}, 32'd1);
      @(negedge clk_in);
      req_valid_in = 1'b0;
      chk("held_issue_en", {31'd0, mem_en_out}, 32'd1);
      chk("held_issue_addr", {{(32-AW){1'b0}}, mem_addr_out}, 32'd4);
      drain();

      // reset during WAIT abandons the load
      wait_ready();
      req_valid_in = 1'b1; req_we_in = 1'b0; req_funct3_in = 3'b010; req_addr_in = 32'h10;
      @(negedge clk_in);
      req_valid_in = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      chk("rstw_mem_en", {31'd0, mem_en_out}, 32'd0);
      chk("rstw_resp_valid", {31'd0, resp_valid_out}, 32'd0);
      chk("rstw_resp_data", resp_data_out, 32'd0);
      chk("rstw_mem_we", {28'd0, mem_we_out}, 32'd0);
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b1;
      #1;
      chk("rstw_ready_after", {31'd0, req_ready_out}, 32'd1);
      repeat (6) @(negedge clk_in);
      issue("lwpost", 1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 14'd4, 4'b0000, 32'd0, 1'b0, 32'h12345678);

      repeat (3) @(negedge clk_in);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
